// File: rtl/grid_position_mapper_if.sv
// Request/result bundle for grid_position_mapper.
//   in_valid/in_ready : request handshake, in_x/in_y carry N_SQ packed pixel coords
//   out_valid/out_ready: result handshake, out_col/out_row packed grid indices,
//                        out_oob/out_misal per-square flags, out_any_oob = |out_oob
// master: the requester/consumer side; slave: the mapper.
interface grid_position_mapper_if #(
  parameter int unsigned N_SQ    = 4,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned POS_W   = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_SQ*COORD_W-1:0]   in_x;
  logic [N_SQ*COORD_W-1:0]   in_y;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_SQ*POS_W-1:0]     out_col;
  logic [N_SQ*POS_W-1:0]     out_row;
  logic [N_SQ-1:0]           out_oob;
  logic [N_SQ-1:0]           out_misal;
  logic                      out_any_oob;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_col, out_row, out_oob, out_misal, out_any_oob
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_col, out_row, out_oob, out_misal, out_any_oob
  );
endinterface

// File: rtl/grid_position_mapper.sv
// grid_position_mapper: maps pixel coordinates of N_SQ piece squares to
// playfield (column, row) cells using subtract-per-cycle division, flagging
// squares outside the playfield (oob) or not on a cell boundary (misal).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : grid_position_mapper_if.slave (request in, result out)
module grid_position_mapper #(
  parameter int unsigned N_SQ     = 4,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned POS_W    = 5,
  parameter int unsigned CELL     = 20,
  parameter int unsigned X_ORIGIN = 240,
  parameter int unsigned Y_ORIGIN = 40,
  parameter int unsigned COLS     = 10,
  parameter int unsigned ROWS     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  grid_position_mapper_if.slave  bus
);

  localparam int unsigned K_W = (N_SQ > 1) ? $clog2(N_SQ) : 1;
  localparam int unsigned D_W = COORD_W + 1;

  localparam logic signed [D_W-1:0] X_ORG  = D_W'(X_ORIGIN);
  localparam logic signed [D_W-1:0] Y_ORG  = D_W'(Y_ORIGIN);
  localparam logic signed [D_W-1:0] X_LIM  = D_W'(COLS * CELL);
  localparam logic signed [D_W-1:0] Y_LIM  = D_W'(ROWS * CELL);
  localparam logic [COORD_W-1:0]    CELL_R = COORD_W'(CELL);
  localparam logic [K_W-1:0]        K_LAST = K_W'(N_SQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t                  state;
  logic [K_W-1:0]          k;
  logic [N_SQ*COORD_W-1:0] x_q;
  logic [N_SQ*COORD_W-1:0] y_q;
  logic [COORD_W-1:0]      rem_x;
  logic [COORD_W-1:0]      rem_y;
  logic [POS_W-1:0]        qx;
  logic [POS_W-1:0]        qy;

  logic signed [D_W-1:0]   dx;
  logic signed [D_W-1:0]   dy;
  logic                    load_oob;
  logic                    div_done;
  logic                    last_sq;
  logic [N_SQ-1:0]         oob_upd;

  always_comb begin
    dx       = $signed({1'b0, x_q[k*COORD_W +: COORD_W]}) - X_ORG;
    dy       = $signed({1'b0, y_q[k*COORD_W +: COORD_W]}) - Y_ORG;
    load_oob = (dx < 0) || (dy < 0) || (dx >= X_LIM) || (dy >= Y_LIM);
    div_done = (rem_x < CELL_R) && (rem_y < CELL_R);
    last_sq  = (k == K_LAST);
    // out_any_oob must track out_oob exactly, so both come from this vector
    oob_upd    = bus.out_oob;
    oob_upd[k] = (state == LOAD) && load_oob;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      k               <= '0;
      x_q             <= '0;
      y_q             <= '0;
      rem_x           <= '0;
      rem_y           <= '0;
      qx              <= '0;
      qy              <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_col     <= '0;
      bus.out_row     <= '0;
      bus.out_oob     <= '0;
      bus.out_misal   <= '0;
      bus.out_any_oob <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q          <= bus.in_x;
            y_q          <= bus.in_y;
            k            <= '0;
            bus.in_ready <= 1'b0;
            state        <= LOAD;
          end
        end

        LOAD: begin
          if (load_oob) begin
            bus.out_col[k*POS_W +: POS_W] <= '0;
            bus.out_row[k*POS_W +: POS_W] <= '0;
            bus.out_misal[k]              <= 1'b0;
            bus.out_oob                   <= oob_upd;
            bus.out_any_oob               <= |oob_upd;
            if (last_sq) state <= DONE;
            else begin
              k     <= k + 1'b1;
              state <= LOAD;
            end
          end else begin
            rem_x <= dx[COORD_W-1:0];
            rem_y <= dy[COORD_W-1:0];
            qx    <= '0;
            qy    <= '0;
            state <= DIV;
          end
        end

        DIV: begin
          if (div_done) begin
            bus.out_col[k*POS_W +: POS_W] <= qx;
            bus.out_row[k*POS_W +: POS_W] <= qy;
            bus.out_misal[k]              <= (rem_x != '0) || (rem_y != '0);
            bus.out_oob                   <= oob_upd;
            bus.out_any_oob               <= |oob_upd;
            if (last_sq) state <= DONE;
            else begin
              k     <= k + 1'b1;
              state <= LOAD;
            end
          end else begin
            if (rem_x >= CELL_R) begin
              rem_x <= rem_x - CELL_R;
              qx    <= qx + 1'b1;
            end
            if (rem_y >= CELL_R) begin
              rem_y <= rem_y - CELL_R;
              qy    <= qy + 1'b1;
            end
          end
        end

        DONE: begin
          // first DONE cycle raises out_valid so results settle one edge before presentation
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
